// File: rtl/serial_number_transmitter_if.sv
// serial_number_transmitter_if: number-in handshake and MSB-first serial bit stream
interface serial_number_transmitter_if #(
   parameter int W = 16,
   localparam int LW = $clog2(W + 1)
);
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [LW-1:0] in_len;
   logic          bit_valid;
   logic          out_ready;
   logic          bit_out;
   logic          bit_first;
   logic          bit_last;
   modport master (
      output in_valid, in_data, in_len, out_ready,
      input  in_ready, bit_valid, bit_out, bit_first, bit_last
   );
   modport slave (
      input  in_valid, in_data, in_len, out_ready,
      output in_ready, bit_valid, bit_out, bit_first, bit_last
   );
endinterface

// File: rtl/serial_number_transmitter.sv
// serial_number_transmitter: shifts a number out MSB-first while tracking its value mod DIV
module serial_number_transmitter #(
   parameter int W = 16,
   parameter int DIV = 5,
   localparam int RW = $clog2(DIV),
   localparam int LW = $clog2(W + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   serial_number_transmitter_if.slave s,
   output logic [RW-1:0]              remainder,
   output logic                       divisible,
   output logic                       done
);
   typedef enum logic {IDLE, SEND} state_t;
   localparam logic [RW:0] DV = (RW + 1)'(DIV);
   localparam logic [LW-1:0] WL = LW'(W);
   state_t        state, state_nx;
   logic [W-1:0]  shreg;
   logic [LW-1:0] cnt, len_eff;
   logic          first, accept, xfer, last_xfer;
   logic [RW:0]   t;
   assign len_eff = (s.in_len == '0 || s.in_len > WL) ? WL : s.in_len;
   assign t = {remainder, shreg[W-1]};
   assign divisible = (remainder == '0);
   // state register
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nx;
   // next state plus handshake and stream outputs
   always_comb begin
      s.in_ready = (state == IDLE);
      s.bit_valid = (state == SEND);
      s.bit_out = (state == SEND) ? shreg[W-1] : 1'b0;
      s.bit_first = (state == SEND) && first;
      s.bit_last = (state == SEND) && (cnt == LW'(1));
      accept = (state == IDLE) && s.in_valid;
      xfer = (state == SEND) && s.out_ready;
      last_xfer = xfer && (cnt == LW'(1));
      state_nx = accept ? SEND : last_xfer ? IDLE : state;
   end
   // left-aligned shift register, bit counter and running remainder (one conditional subtract)
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         shreg <= '0;
         cnt <= '0;
         first <= 1'b0;
         remainder <= '0;
         done <= 1'b0;
      end else begin
         done <= last_xfer;
         if (accept) begin
            shreg <= s.in_data << (WL - len_eff);
            cnt <= len_eff;
            remainder <= '0;
            first <= 1'b1;
         end else if (xfer) begin
            shreg <= shreg << 1;
            cnt <= cnt - LW'(1);
            first <= 1'b0;
            remainder <= RW'((t >= DV) ? t - DV : t);
         end
      end
endmodule

// File: tb/tb_serial_number_transmitter.sv
// tb_serial_number_transmitter: directed checks of the serial transmitter with DIV=5 and DIV=3 instances
module tb_serial_number_transmitter;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, out_ready;
   logic [15:0] in_data;
   logic [4:0]  in_len;
   logic [2:0]  rem5;
   logic [1:0]  rem3;
   logic        div5, div3, done5, done3;
   int          n_cmp = 0;
   int          n_err = 0;
   serial_number_transmitter_if #(.W(16)) i5 ();
   serial_number_transmitter_if #(.W(16)) i3 ();
   assign i5.in_valid = in_valid;
   assign i5.in_data = in_data;
   assign i5.in_len = in_len;
   assign i5.out_ready = out_ready;
   assign i3.in_valid = in_valid;
   assign i3.in_data = in_data;
   assign i3.in_len = in_len;
   assign i3.out_ready = out_ready;
   serial_number_transmitter #(.W(16), .DIV(5)) u5 (
      .clk(clk), .rst(rst), .s(i5.slave), .remainder(rem5), .divisible(div5), .done(done5));
   serial_number_transmitter #(.W(16), .DIV(3)) u3 (
      .clk(clk), .rst(rst), .s(i3.slave), .remainder(rem3), .divisible(div3), .done(done3));
   always #5 clk = ~clk;
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic check_reset();
      check("rst_in_ready", i5.in_ready, 1);
      check("rst_bit_valid", i5.bit_valid, 0);
      check("rst_bit_out", i5.bit_out, 0);
      check("rst_bit_first", i5.bit_first, 0);
      check("rst_bit_last", i5.bit_last, 0);
      check("rst_rem5", rem5, 0);
      check("rst_div5", div5, 1);
      check("rst_done5", done5, 0);
      check("rst_rem3", rem3, 0);
      check("rst_div3", div3, 1);
      check("rst_done3", done3, 0);
   endtask
   // called at a negedge; offers the number, then follows each bit to the done pulse
   task automatic send(input logic [15:0] d, input logic [4:0] l, input int n, input bit hold,
                       input int stall, input int fr5, input int fr3);
      int   r5, r3;
      logic b;
      in_valid = 1'b1;
      in_data = d;
      in_len = l;
      out_ready = 1'b1;
      check("in_ready", i5.in_ready, 1);
      check("bubble_valid", i5.bit_valid, 0);
      @(negedge clk);
      if (!hold) in_valid = 1'b0;
      r5 = 0;
      r3 = 0;
      for (int i = 0; i < n; i++) begin
         b = d[n-1-i];
         check("bit_valid", i5.bit_valid, 1);
         check("bit_out", i5.bit_out, b);
         check("bit_first", i5.bit_first, i == 0);
         check("bit_last", i5.bit_last, i == n - 1);
         check("in_ready_busy", i5.in_ready, 0);
         if (i == 1)
            for (int k = 0; k < stall; k++) begin
               out_ready = 1'b0;
               @(negedge clk);
               check("stall_valid", i5.bit_valid, 1);
               check("stall_bit", i5.bit_out, b);
               check("stall_first", i5.bit_first, 0);
               check("stall_rem5", rem5, r5);
               check("stall_rem3", rem3, r3);
            end
         out_ready = 1'b1;
         @(negedge clk);
         r5 = (2 * r5 + int'(b)) % 5;
         r3 = (2 * r3 + int'(b)) % 3;
         check("rem5", rem5, r5);
         check("rem3", rem3, r3);
         check("done5", done5, i == n - 1);
      end
      check("final_rem5", rem5, fr5);
      check("final_rem3", rem3, fr3);
      check("div5", div5, fr5 == 0);
      check("div3", div3, fr3 == 0);
      check("done3", done3, 1);
   endtask
   initial begin
      rst = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      in_len = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_reset();
      rst = 1'b1;
      @(negedge clk);
      send(16'h000A, 5'd4, 4, 1'b0, 0, 0, 1);
      @(negedge clk);
      check("done_one_cycle", done5, 0);
      check("rem5_hold", rem5, 0);
      check("rem3_hold", rem3, 1);
      check("div5_hold", div5, 1);
      send(16'hFFFF, 5'd0, 16, 1'b0, 0, 0, 0);
      @(negedge clk);
      send(16'hFFFF, 5'd20, 16, 1'b0, 0, 0, 0);
      @(negedge clk);
      send(16'h0007, 5'd3, 3, 1'b0, 3, 2, 1);
      @(negedge clk);
      send(16'h0003, 5'd3, 3, 1'b1, 0, 3, 0);
      send(16'h0004, 5'd3, 3, 1'b0, 0, 4, 1);
      @(negedge clk);
      check("done_after_pair", done5, 0);
      in_valid = 1'b1;
      in_data = 16'hA5A5;
      in_len = 5'd16;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_reset_rem5", rem5, 2);
      check("pre_reset_valid", i5.bit_valid, 1);
      rst = 1'b0;
      #1;
      check_reset();
      @(negedge clk);
      check("reset_hold_done", done5, 0);
      rst = 1'b1;
      @(negedge clk);
      check("post_reset_done", done5, 0);
      check("post_reset_valid", i5.bit_valid, 0);
      send(16'h000A, 5'd4, 4, 1'b0, 0, 0, 1);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/serial_number_transmitter.md
Name: serial_number_transmitter

Overview:
Parallel-to-serial source for the serial divisibility checkers. Accepts a W-bit number over a valid/ready handshake and emits its bits MSB-first, one bit per accepted transfer, on a new_bit-style stream. Also keeps a running remainder mod DIV of the bits sent so far, which serves as the reference value when checking downstream serial FSMs.

Parameters:
W, 16, width of the input number and maximum bit count
DIV, 5, divisor for the running remainder; legal range 2..255
RW, $clog2(DIV), remainder width (derived; not overridden)
LW, $clog2(W+1), in_len width (derived; not overridden)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
in_valid  input  1  input number offered
in_ready  output  1  block can accept a number
in_data  input  W  number; the low in_len bits are sent
in_len  input  LW  number of bits to send; 0 or >W means W
bit_valid  output  1  bit_out carries a valid bit
out_ready  input  1  downstream accepts the bit this cycle
bit_out  output  1  current serial bit, MSB-first
bit_first  output  1  bit_out is the first bit of the number
bit_last  output  1  bit_out is the last bit of the number
remainder  output  RW  value of the bits transferred so far, mod DIV
divisible  output  1  remainder == 0
done  output  1  one-cycle pulse after the last bit transfers

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, in_ready=1, bit_valid=0, bit_out=0, bit_first=0, bit_last=0, remainder=0, divisible=1, done=0; shift register and counter cleared.
- Reset asserted mid-number aborts it immediately. No partial completion; done does not pulse.
- FSM states: IDLE, SEND.
- IDLE: in_ready=1.
  - On in_valid&&in_ready: latch shreg = in_data << (W-len_eff), cnt = len_eff, remainder = 0, first flag = 1.
  - Next state SEND. Latency from accept to first bit_valid is 1 cycle.
- SEND: in_ready=0, bit_valid=1, bit_out=shreg[W-1], bit_first=first flag, bit_last=(cnt==1).
  - A transfer occurs when bit_valid&&out_ready. On a transfer: shreg shifts left by 1, cnt decrements, first flag clears.
  - remainder updates on each transfer: t = 2*remainder + bit_out; remainder = (t >= DIV) ? t-DIV : t. t needs RW+1 bits; one conditional subtract always suffices.
  - Backpressure (out_ready=0): bit_out, bit_first and bit_last hold stable; remainder holds.
- Last transfer (bit_last&&out_ready): next state IDLE, done=1 for exactly one cycle. remainder and divisible then hold the final value until the next accept.
- in_valid seen in SEND is ignored; no accept occurs. An in_valid held high is accepted in the first IDLE cycle, the same cycle done pulses. Minimum gap between numbers is 1 cycle without bit_valid.
- len_eff = (in_len==0 || in_len>W) ? W : in_len. A single-bit number has bit_first and bit_last set together.
- divisible is combinational from the remainder register.
- bit_out is driven 0 while bit_valid=0.

Test Plan:
- W=16, DIV=5, in_data=0x000A, in_len=4, out_ready=1 -> bits 1,0,1,0 on 4 consecutive cycles; bit_first on bit 1, bit_last on bit 4; remainder after each transfer 1,2,0,0; done pulses with divisible=1.
- in_data=0xFFFF, in_len=0 -> 16 bits all 1, final remainder 0 (65535 mod 5), done once; in_len=20 gives the same result.
- in_data=0x0007, in_len=3; out_ready low for 3 cycles after the first bit -> bit_out=1 and bit_valid held during the stall, remainder stays 1; final remainder 2 (7 mod 5).
- in_valid held high, numbers 0x0003 then 0x0004 with in_len=3 -> second accept in the done cycle; final remainders 3 then 4; one bubble cycle between the two numbers.
- rst pulsed low after the 2nd bit of a 16-bit number -> all outputs at reset values immediately, no done pulse; the next number sends correctly from its first bit.
- DIV=3 instance, in_data=0x0007, in_len=3 -> remainder sequence 1,0,1; divisible=0 at done.
